// File: rtl/uart_tx_sched_if.sv
// Handshake bundle between the byte requesters, the UART scheduler and the UART transmitter.
interface uart_tx_sched_if #(
    parameter int NUM_REQ   = 4,
    parameter int UART_SIZE = 8
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*UART_SIZE-1:0] req_data;
    logic [NUM_REQ-1:0]           req_ready;
    logic                         CTS;
    logic                         tx_start;
    logic [UART_SIZE-1:0]         tx_data;
    logic                         tx_busy;
    logic [ID_W-1:0]              grant_id;
    logic                         sched_busy;

    modport master (
        output req_valid, req_data, CTS, tx_busy,
        input  req_ready, tx_start, tx_data, grant_id, sched_busy
    );

    modport slave (
        input  req_valid, req_data, CTS, tx_busy,
        output req_ready, tx_start, tx_data, grant_id, sched_busy
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte requesters,
// with bounded bursts per grant and CTS flow control applied only before a byte is accepted.
module uart_tx_sched #(
    parameter int NUM_REQ   = 4,
    parameter int UART_SIZE = 8,
    parameter int MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_sched_if.slave bus
);
    localparam int              ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int              BC_W      = $clog2(MAX_BURST + 1);
    localparam logic [BC_W-1:0] BURST_MAX = BC_W'(MAX_BURST);
    localparam logic [ID_W-1:0] LAST_INIT = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} state_t;

    state_t               state, state_nxt;
    logic [ID_W-1:0]      grant_id, last_grant, rr_pick, rr_cand;
    logic [BC_W-1:0]      burst_cnt;
    logic                 rr_found, grant_valid, accept, release_grant;
    logic [UART_SIZE-1:0] grant_data;
    logic                 tx_start_p1;
    logic [UART_SIZE-1:0] tx_data_p1;

    assign grant_valid = bus.req_valid[grant_id];
    assign grant_data  = bus.req_data[int'(grant_id)*UART_SIZE +: UART_SIZE];

    // Search upward from the requester after the last one served, wrapping.
    always_comb begin
        rr_pick  = last_grant;
        rr_cand  = last_grant;
        rr_found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            rr_cand = ID_W'((int'(last_grant) + i) % NUM_REQ);
            if (!rr_found && bus.req_valid[rr_cand]) begin
                rr_pick  = rr_cand;
                rr_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        release_grant = 1'b0;
        bus.req_ready = '0;
        case (state)
            IDLE: begin
                if (bus.CTS && rr_found) state_nxt = SEND;
            end
            SEND: begin
                accept                  = grant_valid && bus.CTS && !bus.tx_busy;
                bus.req_ready[grant_id] = accept;
                if (accept) begin
                    state_nxt = WAIT_ACK;
                end else if (!grant_valid) begin
                    state_nxt     = IDLE;
                    release_grant = 1'b1;
                end
            end
            WAIT_ACK: begin
                if (bus.tx_busy) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    if (burst_cnt < BURST_MAX && grant_valid) begin
                        state_nxt = SEND;
                    end else begin
                        state_nxt     = IDLE;
                        release_grant = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p1: accepted byte and its launch pulse, one cycle after the handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_id    <= '0;
            last_grant  <= LAST_INIT;
            burst_cnt   <= '0;
            tx_start_p1 <= 1'b0;
            tx_data_p1  <= '0;
        end else begin
            tx_start_p1 <= accept;
            if (state == IDLE && bus.CTS && rr_found) begin
                grant_id  <= rr_pick;
                burst_cnt <= '0;
            end
            if (accept) begin
                tx_data_p1 <= grant_data;
                if (burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + BC_W'(1);
            end
            if (release_grant) last_grant <= grant_id;
        end
    end

    assign bus.tx_start   = tx_start_p1;
    assign bus.tx_data    = tx_data_p1;
    assign bus.grant_id   = grant_id;
    assign bus.sched_busy = (state != IDLE);
endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: transaction-level reference model, transmitter model, directed and random stimulus.
module tb_uart_tx_sched;
    localparam int NUM_REQ   = 4;
    localparam int UART_SIZE = 8;
    localparam int MAX_BURST = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    uart_tx_sched_if #(.NUM_REQ(NUM_REQ), .UART_SIZE(UART_SIZE)) bus ();

    uart_tx_sched #(.NUM_REQ(NUM_REQ), .UART_SIZE(UART_SIZE), .MAX_BURST(MAX_BURST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int tx_dly_cfg = 1;
    int tx_len_cfg = 3;

    // Event logs observed from the DUT
    int acc_id[$];
    int acc_data[$];
    int acc_cyc[$];
    int start_data[$];
    int start_cyc[$];

    // Reference model: session = one grant, a byte is in flight from accept until tx_busy has risen and fallen
    bit m_active, m_inflight, m_seen, m_start;
    int m_g, m_last, m_cnt, m_data;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int qat(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    function automatic int rr_next(input int last, input logic [NUM_REQ-1:0] v);
        for (int k = 1; k <= NUM_REQ; k++)
            if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        return last;
    endfunction

    task automatic model_reset();
        m_active = 0; m_inflight = 0; m_seen = 0; m_start = 0;
        m_g = 0; m_last = NUM_REQ - 1; m_cnt = 0; m_data = 0;
    endtask

    task automatic clear_logs();
        acc_id.delete(); acc_data.delete(); acc_cyc.delete();
        start_data.delete(); start_cyc.delete();
    endtask

    task automatic set_byte(input int i, input logic [UART_SIZE-1:0] b);
        bus.req_data[i*UART_SIZE +: UART_SIZE] = b;
    endtask

    // sel: 0 scheduler idle, 1 scheduler busy, 2 transmitter busy, 3 at least n accepts logged
    task automatic wait_cond(input int sel, input int n, input string name);
        int t;
        bit ok;
        t = 0;
        forever begin
            case (sel)
                0:       ok = !bus.sched_busy;
                1:       ok = bus.sched_busy;
                2:       ok = bus.tx_busy;
                default: ok = (acc_id.size() >= n);
            endcase
            if (ok || t >= 400) break;
            @(posedge clk); #1;
            t++;
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL %s_timeout: condition not reached within %0d cycles", name, t);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        bus.req_valid = '0;
        bus.CTS = 1'b0;
        tx_dly_cfg = 1;
        tx_len_cfg = 3;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        clear_logs();
    endtask

    // Transmitter model: busy starts tx_dly_cfg cycles after tx_start and lasts tx_len_cfg cycles
    initial begin : tx_model
        int wait_c, left_c;
        wait_c = 0;
        left_c = 0;
        bus.tx_busy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!reset) begin
                bus.tx_busy = 1'b0; wait_c = 0; left_c = 0;
            end else if (bus.tx_start) begin
                if (tx_dly_cfg == 0) begin bus.tx_busy = 1'b1; left_c = tx_len_cfg; end
                else wait_c = tx_dly_cfg;
            end else if (wait_c > 0) begin
                wait_c--;
                if (wait_c == 0) begin bus.tx_busy = 1'b1; left_c = tx_len_cfg; end
            end else if (bus.tx_busy) begin
                left_c--;
                if (left_c == 0) bus.tx_busy = 1'b0;
            end
        end
    end

    initial begin : compare
        logic [NUM_REQ-1:0] v;
        logic cts, busy;
        int exp_ready;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                model_reset();
                chk("rst_req_ready",  int'(bus.req_ready), 0);
                chk("rst_tx_start",   int'(bus.tx_start), 0);
                chk("rst_tx_data",    int'(bus.tx_data), 0);
                chk("rst_grant_id",   int'(bus.grant_id), 0);
                chk("rst_sched_busy", int'(bus.sched_busy), 0);
            end else begin
                v = bus.req_valid; cts = bus.CTS; busy = bus.tx_busy;
                exp_ready = (m_active && !m_inflight && v[m_g] && cts && !busy) ? (1 << m_g) : 0;
                chk("req_ready",  int'(bus.req_ready), exp_ready);
                chk("tx_start",   int'(bus.tx_start), int'(m_start));
                chk("tx_data",    int'(bus.tx_data), m_data);
                chk("grant_id",   int'(bus.grant_id), m_g);
                chk("sched_busy", int'(bus.sched_busy), int'(m_active));
                for (int k = 0; k < NUM_REQ; k++)
                    if (bus.req_ready[k]) begin
                        acc_id.push_back(k);
                        acc_data.push_back(int'(bus.req_data[k*UART_SIZE +: UART_SIZE]));
                        acc_cyc.push_back(cyc);
                    end
                if (bus.tx_start) begin
                    start_data.push_back(int'(bus.tx_data));
                    start_cyc.push_back(cyc);
                end
                // advance the model across the coming rising edge
                m_start = (exp_ready != 0);
                if (!m_active) begin
                    if (cts && v != '0) begin m_active = 1; m_g = rr_next(m_last, v); m_cnt = 0; end
                end else if (!m_inflight) begin
                    if (exp_ready != 0) begin
                        m_inflight = 1; m_seen = 0; m_cnt++;
                        m_data = int'(bus.req_data[m_g*UART_SIZE +: UART_SIZE]);
                    end else if (!v[m_g]) begin
                        m_active = 0; m_last = m_g;
                    end
                end else if (!m_seen) begin
                    if (busy) m_seen = 1;
                end else if (!busy) begin
                    m_inflight = 0;
                    if (!(m_cnt < MAX_BURST && v[m_g])) begin m_active = 0; m_last = m_g; end
                end
            end
        end
    end

    initial begin : stimulus
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.CTS       = 1'b0;

        // Single byte
        do_reset();
        set_byte(0, 8'hA5);
        bus.CTS = 1'b1;
        bus.req_valid = 4'b0001;
        wait_cond(3, 1, "t1_accept");
        bus.req_valid = '0;
        wait_cond(0, 0, "t1_idle");
        chk("t1_accepts",     acc_id.size(), 1);
        chk("t1_accept_id",   qat(acc_id, 0), 0);
        chk("t1_starts",      start_data.size(), 1);
        chk("t1_tx_data",     qat(start_data, 0), 8'hA5);
        chk("t1_start_delay", qat(start_cyc, 0) - qat(acc_cyc, 0), 1);
        chk("t1_idle",        int'(bus.sched_busy), 0);

        // Fairness with all requesters valid
        do_reset();
        for (int k = 0; k < NUM_REQ; k++) set_byte(k, UART_SIZE'(8'h10 + k));
        bus.CTS = 1'b1;
        bus.req_valid = 4'b1111;
        wait_cond(3, 17, "t2_bytes");
        for (int i = 0; i < 17; i++) chk("t2_grant_order", qat(acc_id, i), (i / MAX_BURST) % NUM_REQ);
        chk("t2_data_r1", qat(acc_data, 4), 8'h11);
        bus.req_valid = '0;
        wait_cond(0, 0, "t2_idle");

        // Flow control at the start of SEND
        do_reset();
        set_byte(0, 8'h7E);
        bus.CTS = 1'b1;
        bus.req_valid = 4'b0001;
        wait_cond(1, 0, "t3_grant");
        bus.CTS = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("t3_no_accept", acc_id.size(), 0);
        chk("t3_no_start",  start_data.size(), 0);
        chk("t3_held",      int'(bus.sched_busy), 1);
        bus.CTS = 1'b1;
        @(posedge clk); #1;
        chk("t3_accept_on_cts", acc_id.size(), 1);
        bus.req_valid = '0;
        wait_cond(0, 0, "t3_idle");
        chk("t3_one_start", start_data.size(), 1);
        chk("t3_tx_data",   qat(start_data, 0), 8'h7E);

        // CTS drop mid-character
        do_reset();
        tx_len_cfg = 6;
        set_byte(0, 8'h3C);
        bus.CTS = 1'b1;
        bus.req_valid = 4'b0001;
        wait_cond(2, 0, "t4_txbusy");
        bus.CTS = 1'b0;
        bus.req_valid = '0;
        wait_cond(0, 0, "t4_idle");
        chk("t4_one_start", start_data.size(), 1);
        chk("t4_tx_data",   qat(start_data, 0), 8'h3C);
        chk("t4_accepts",   acc_id.size(), 1);

        // Early release by requester 2, then requester 3 is next
        do_reset();
        for (int k = 0; k < NUM_REQ; k++) set_byte(k, UART_SIZE'(8'hC0 + k));
        bus.CTS = 1'b1;
        bus.req_valid = 4'b0100;
        wait_cond(3, 2, "t5_two_bytes");
        bus.req_valid = '0;
        wait_cond(0, 0, "t5_idle");
        bus.req_valid = 4'b1001;
        wait_cond(3, 3, "t5_next");
        chk("t5_acc0", qat(acc_id, 0), 2);
        chk("t5_acc1", qat(acc_id, 1), 2);
        chk("t5_acc2", qat(acc_id, 2), 3);
        bus.req_valid = '0;
        wait_cond(0, 0, "t5_idle2");

        // Reset while waiting for the transmitter
        do_reset();
        tx_len_cfg = 8;
        set_byte(1, 8'h5A);
        set_byte(0, 8'h01);
        bus.CTS = 1'b1;
        bus.req_valid = 4'b0010;
        wait_cond(2, 0, "t6_txbusy");
        @(posedge clk); #1;
        chk("t6_pre_grant", int'(bus.grant_id), 1);
        chk("t6_pre_data",  int'(bus.tx_data), 8'h5A);
        reset = 1'b0;
        #1;
        chk("t6_rst_tx_start",   int'(bus.tx_start), 0);
        chk("t6_rst_tx_data",    int'(bus.tx_data), 0);
        chk("t6_rst_grant_id",   int'(bus.grant_id), 0);
        chk("t6_rst_sched_busy", int'(bus.sched_busy), 0);
        chk("t6_rst_req_ready",  int'(bus.req_ready), 0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        clear_logs();
        bus.req_valid = 4'b0011;
        wait_cond(3, 1, "t6_post");
        chk("t6_first_grant", qat(acc_id, 0), 0);
        bus.req_valid = '0;
        wait_cond(0, 0, "t6_idle");
        chk("t6_one_start", start_data.size(), 1);

        // Randomized traffic, flow control and transmitter timing
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (c == 1500) reset = 1'b0;
            if (c == 1503) reset = 1'b1;
            for (int k = 0; k < NUM_REQ; k++) begin
                bus.req_valid[k] = ($urandom_range(0, 3) != 0);
                set_byte(k, UART_SIZE'($urandom));
            end
            bus.CTS    = ($urandom_range(0, 7) != 0);
            tx_dly_cfg = $urandom_range(0, 2);
            tx_len_cfg = $urandom_range(1, 4);
        end
        bus.req_valid = '0;
        bus.CTS = 1'b1;
        wait_cond(0, 0, "rand_idle");
        chk("rand_traffic_seen", int'(acc_id.size() > 50), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
- REQ-001: Parameter NUM_REQ, default 4; number of byte requesters sharing one UART transmitter.
- REQ-002: Parameter UART_SIZE, default 8; width of one character in bits.
- REQ-003: Parameter MAX_BURST, default 4; maximum bytes per grant before forced re-arbitration.
- REQ-004: Port clk  input  1  single clock; all state updates on its rising edge.
- REQ-005: Port reset  input  1  asynchronous, active-low reset.
- REQ-006: Port req_valid  input  NUM_REQ  per-requester byte available.
- REQ-007: Port req_data  input  NUM_REQ*UART_SIZE  per-requester byte; requester i occupies bits [i*UART_SIZE +: UART_SIZE].
- REQ-008: Port req_ready  output  NUM_REQ  per-requester byte accepted this cycle.
- REQ-009: Port CTS  input  1  clear-to-send from the far end; high permits a new byte.
- REQ-010: Port tx_start  output  1  one-cycle pulse launching a character on the UART transmitter.
- REQ-011: Port tx_data  output  UART_SIZE  character for the transmitter; stable from tx_start until tx_busy falls.
- REQ-012: Port tx_busy  input  1  transmitter busy from start bit through stop bit.
- REQ-013: Port grant_id  output  $clog2(NUM_REQ)  index of the current or most recent grant.
- REQ-014: Port sched_busy  output  1  high in every state except IDLE.

Function
- REQ-015: The FSM SHALL have states IDLE, SEND, WAIT_ACK and WAIT_DONE.
- REQ-016: In IDLE with CTS high and any req_valid set, the block SHALL grant the first set bit searching upward from last_grant+1, wrapping modulo NUM_REQ, load grant_id, clear burst_cnt, and enter SEND next cycle.
- REQ-017: In IDLE with CTS low, no grant SHALL be issued, whatever the state of req_valid.
- REQ-018: In SEND, req_ready[grant_id] SHALL be combinationally req_valid[grant_id] & CTS & !tx_busy; every other req_ready bit SHALL be 0 in all states.
- REQ-019: On a SEND cycle where req_ready[grant_id] is high, the block SHALL register req_data[grant_id] into tx_data, increment burst_cnt, and enter WAIT_ACK.
- REQ-020: tx_start SHALL be high for exactly the first cycle of WAIT_ACK, one cycle after the accepting handshake.
- REQ-021: WAIT_ACK SHALL move to WAIT_DONE on the first cycle tx_busy is high, and SHALL hold otherwise, with no timeout.
- REQ-022: WAIT_DONE SHALL hold while tx_busy is high.
- REQ-023: When tx_busy falls, WAIT_DONE SHALL return to SEND if burst_cnt < MAX_BURST and req_valid[grant_id] is high.
- REQ-024: When tx_busy falls and the condition of REQ-023 does not hold, the block SHALL go to IDLE and set last_grant to grant_id.
- REQ-025: If CTS goes low in SEND, the block SHALL stall without accepting a byte and keep the grant; if req_valid[grant_id] drops first, it SHALL go to IDLE and update last_grant.
- REQ-026: If CTS goes low during WAIT_ACK or WAIT_DONE, the byte in flight SHALL complete and the block SHALL NOT abort it.
- REQ-027: Requests arriving while a grant is active SHALL wait; a single requester SHALL receive at most MAX_BURST consecutive bytes while another request is pending.
- REQ-028: burst_cnt SHALL be $clog2(MAX_BURST+1) bits wide and SHALL never wrap.

Reset
- REQ-029: While reset is low, the block SHALL force the FSM to IDLE, req_ready=0, tx_start=0, tx_data=0, grant_id=0, sched_busy=0, burst_cnt=0 and last_grant=NUM_REQ-1, so requester 0 wins first.
- REQ-030: Reset asserted mid-byte SHALL abandon the byte with no tx_start re-issue; after release the block SHALL resume in IDLE on the first clock edge.

Verification
- REQ-031: Single byte -> with CTS=1 and req_valid=0001, data 0xA5, the bench SHALL see req_ready[0] for one cycle, tx_start one cycle later, tx_data=0xA5, and the block back in IDLE after tx_busy falls.
- REQ-032: Fairness -> with all four requesters valid continuously and MAX_BURST=4, grant order SHALL be 0,1,2,3,0 with exactly 4 bytes each.
- REQ-033: Flow control -> CTS low at the start of SEND SHALL give no req_ready and no tx_start; when CTS returns high, the byte SHALL be accepted that cycle.
- REQ-034: CTS drop mid-character -> CTS low during WAIT_DONE SHALL let the byte finish, with exactly one tx_start.
- REQ-035: Early release -> if requester 2 drops req_valid after 2 bytes, the block SHALL go to IDLE with last_grant=2 and grant requester 3 next when it is valid.
- REQ-036: Reset in WAIT_DONE -> all outputs SHALL be 0 and grant_id=0 immediately, and the first post-reset grant SHALL go to requester 0.
